// File: rtl/tdp_ram_ctrl.sv
// tdp_ram_ctrl: parametrised true-dual-port synchronous RAM.
//
// Two symmetric read/write ports share one word array. Each port has
// per-byte write enables and a read strobe with a matching valid strobe.
// There is an optional second output register, and a clear engine that
// zeroes every word after reset release.
//
// Ports:
//   clk, rst_n         single rising-edge clock, async active-low reset
//   busy               clear engine running; port requests are ignored
//   address_x          word address (x = a, b)
//   wren_x, byteena_x  write strobe and byte-lane enables
//   data_x             write data
//   rden_x             read strobe
//   q_x, q_valid_x     read data and its one-cycle valid strobe
//   collision          one-cycle pulse: both ports wrote the same word
//                      with overlapping byte lanes
module tdp_ram_ctrl #(
    parameter int WIDTHAD        = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int OUT_REG        = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    output logic                      busy,
    input  logic [WIDTHAD-1:0]        address_a,
    input  logic                      wren_a,
    input  logic [DATA_WIDTH/8-1:0]   byteena_a,
    input  logic [DATA_WIDTH-1:0]     data_a,
    input  logic                      rden_a,
    output logic [DATA_WIDTH-1:0]     q_a,
    output logic                      q_valid_a,
    input  logic [WIDTHAD-1:0]        address_b,
    input  logic                      wren_b,
    input  logic [DATA_WIDTH/8-1:0]   byteena_b,
    input  logic [DATA_WIDTH-1:0]     data_b,
    input  logic                      rden_b,
    output logic [DATA_WIDTH-1:0]     q_b,
    output logic                      q_valid_b,
    output logic                      collision
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int DEPTH = 1 << WIDTHAD;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    // Expand byte-lane enables into a per-bit mask.
    function automatic logic [DATA_WIDTH-1:0] lane_mask(input logic [NB-1:0] be);
        logic [DATA_WIDTH-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < NB; i++) begin
            m[8*i +: 8] = {8{be[i]}};
        end
        return m;
    endfunction

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    logic [0:0]         state;
    logic [WIDTHAD-1:0] clr_cnt;
    logic               idle;

    assign idle = (state == ST_IDLE);
    assign busy = ~idle;

    // ------------------------------------------------------------------
    // Clear engine
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
            clr_cnt <= '0;
        end else if (state == ST_CLEAR) begin
            clr_cnt <= clr_cnt + WIDTHAD'(1);
            if (&clr_cnt) begin
                state <= ST_IDLE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Request gating and write-lane arbitration
    // ------------------------------------------------------------------
    logic              wr_a, wr_b, rd_a, rd_b, same_addr;
    logic [NB-1:0]     lane_a, lane_b, own_b;

    assign wr_a      = idle & wren_a;
    assign wr_b      = idle & wren_b;
    assign rd_a      = idle & rden_a;
    assign rd_b      = idle & rden_b;
    assign same_addr = (address_a == address_b);

    assign lane_a = wr_a ? byteena_a : '0;
    assign own_b  = wr_b ? byteena_b : '0;
    // Port A owns any lane it enables on a shared word; B keeps the rest.
    assign lane_b = own_b & ~((wr_a & same_addr) ? byteena_a : '0);

    // ------------------------------------------------------------------
    // Array write (no reset on the storage)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (state == ST_CLEAR) begin
            mem[clr_cnt] <= '0;
        end else begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (lane_a[i]) mem[address_a][8*i +: 8] <= data_a[8*i +: 8];
                if (lane_b[i]) mem[address_b][8*i +: 8] <= data_b[8*i +: 8];
            end
        end
    end

    // ------------------------------------------------------------------
    // Array read: registered old data plus captured same-port write data.
    // Merging after the read register keeps the array a plain synchronous
    // RAM while still returning the port's own new bytes.
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] ram_q_a, ram_q_b;
    logic [DATA_WIDTH-1:0] byp_d_a, byp_d_b;
    logic [DATA_WIDTH-1:0] byp_m_a, byp_m_b;

    always_ff @(posedge clk) begin
        if (rd_a) begin
            ram_q_a <= mem[address_a];
            byp_d_a <= data_a;
            byp_m_a <= lane_mask(lane_a);
        end
        if (rd_b) begin
            ram_q_b <= mem[address_b];
            byp_d_b <= data_b;
            byp_m_b <= lane_mask(own_b);
        end
    end

    // have_x forces the read path to zero until a read completes after reset.
    logic have_a, have_b, v1_a, v1_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            have_a <= 1'b0;
            have_b <= 1'b0;
            v1_a   <= 1'b0;
            v1_b   <= 1'b0;
        end else begin
            v1_a <= rd_a;
            v1_b <= rd_b;
            if (rd_a) have_a <= 1'b1;
            if (rd_b) have_b <= 1'b1;
        end
    end

    logic [DATA_WIDTH-1:0] q1_a, q1_b;

    assign q1_a = have_a ? ((ram_q_a & ~byp_m_a) | (byp_d_a & byp_m_a)) : '0;
    assign q1_b = have_b ? ((ram_q_b & ~byp_m_b) | (byp_d_b & byp_m_b)) : '0;

    // ------------------------------------------------------------------
    // Optional output register
    // ------------------------------------------------------------------
    if (OUT_REG != 0) begin : g_out_reg
        logic [DATA_WIDTH-1:0] q2_a, q2_b;
        logic                  v2_a, v2_b;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                q2_a <= '0;
                q2_b <= '0;
                v2_a <= 1'b0;
                v2_b <= 1'b0;
            end else begin
                v2_a <= v1_a;
                v2_b <= v1_b;
                if (v1_a) q2_a <= q1_a;
                if (v1_b) q2_b <= q1_b;
            end
        end

        assign q_a       = q2_a;
        assign q_b       = q2_b;
        assign q_valid_a = v2_a;
        assign q_valid_b = v2_b;
    end else begin : g_no_out_reg
        assign q_a       = q1_a;
        assign q_b       = q1_b;
        assign q_valid_a = v1_a;
        assign q_valid_b = v1_b;
    end

    // ------------------------------------------------------------------
    // Collision flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            collision <= 1'b0;
        end else begin
            collision <= wr_a & wr_b & same_addr & (|(byteena_a & byteena_b));
        end
    end

endmodule

// File: tb/tb_tdp_ram_ctrl.sv
// tb_tdp_ram_ctrl: scoreboard bench for tdp_ram_ctrl.
//
// Two instances share all inputs: one without and one with the output
// register. The stimulus side keeps a word-array reference model and
// pushes the expected read data, tagged with the cycle in which it must
// appear. A negedge monitor pops and compares. It also checks the hold
// value, busy and collision.
module tb_tdp_ram_ctrl;

    localparam int AW    = 4;
    localparam int DW    = 32;
    localparam int NBL   = DW / 8;
    localparam int DEPTH = 1 << AW;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [AW-1:0]  address_a = '0, address_b = '0;
    logic           wren_a = 1'b0, wren_b = 1'b0, rden_a = 1'b0, rden_b = 1'b0;
    logic [NBL-1:0] byteena_a = '0, byteena_b = '0;
    logic [DW-1:0]  data_a = '0, data_b = '0;

    logic          busy0, busy1, coll0, coll1;
    logic [DW-1:0] q_a0, q_b0, q_a1, q_b1;
    logic          qv_a0, qv_b0, qv_a1, qv_b1;

    tdp_ram_ctrl #(.WIDTHAD(AW), .DATA_WIDTH(DW), .OUT_REG(0), .CLEAR_ON_RESET(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .busy(busy0),
        .address_a(address_a), .wren_a(wren_a), .byteena_a(byteena_a), .data_a(data_a),
        .rden_a(rden_a), .q_a(q_a0), .q_valid_a(qv_a0),
        .address_b(address_b), .wren_b(wren_b), .byteena_b(byteena_b), .data_b(data_b),
        .rden_b(rden_b), .q_b(q_b0), .q_valid_b(qv_b0),
        .collision(coll0)
    );

    tdp_ram_ctrl #(.WIDTHAD(AW), .DATA_WIDTH(DW), .OUT_REG(1), .CLEAR_ON_RESET(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .busy(busy1),
        .address_a(address_a), .wren_a(wren_a), .byteena_a(byteena_a), .data_a(data_a),
        .rden_a(rden_a), .q_a(q_a1), .q_valid_a(qv_a1),
        .address_b(address_b), .wren_b(wren_b), .byteena_b(byteena_b), .data_b(data_b),
        .rden_b(rden_b), .q_b(q_b1), .q_valid_b(qv_b1),
        .collision(coll1)
    );

    typedef struct {
        logic [DW-1:0] d;
        int            due;
    } exp_t;

    exp_t          sbq [4][$];     // 0: dut0 A, 1: dut0 B, 2: dut1 A, 3: dut1 B
    logic [DW-1:0] last_exp [4];
    bit            coll_exp [int];
    logic [DW-1:0] mem_m [DEPTH];
    bit            in_reset = 1'b1;
    int            rel      = 0;
    int            edges    = 0;
    int            tests    = 0;
    int            fails    = 0;

    always @(posedge clk) edges <= edges + 1;

    function automatic void chk(input bit ok, input string name,
                                input logic [DW-1:0] act, input logic [DW-1:0] expv);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, expv, edges);
        end
    endfunction

    // Reference model: a read returns the stored word, with the reading
    // port's own enabled write bytes substituted.
    function automatic logic [DW-1:0] rd_model(input bit [AW-1:0] addr, input bit w,
                                               input bit [NBL-1:0] be, input bit [DW-1:0] d);
        logic [DW-1:0] r;
        r = mem_m[addr];
        if (w) begin
            for (int i = 0; i < NBL; i++) if (be[i]) r[8*i +: 8] = d[8*i +: 8];
        end
        return r;
    endfunction

    function automatic void wr_model(input bit [AW-1:0] addr, input bit [NBL-1:0] be,
                                     input bit [DW-1:0] d);
        for (int i = 0; i < NBL; i++) if (be[i]) mem_m[addr][8*i +: 8] = d[8*i +: 8];
    endfunction

    // One clock cycle of stimulus; the model is updated for the edge
    // that samples these inputs.
    task automatic cyc(input bit wa, input bit [AW-1:0] aa, input bit [NBL-1:0] bea,
                       input bit [DW-1:0] da, input bit ra,
                       input bit wb, input bit [AW-1:0] ab, input bit [NBL-1:0] beb,
                       input bit [DW-1:0] db, input bit rb);
        int e;
        exp_t x;
        wren_a = wa; address_a = aa; byteena_a = bea; data_a = da; rden_a = ra;
        wren_b = wb; address_b = ab; byteena_b = beb; data_b = db; rden_b = rb;
        @(posedge clk);
        #1;
        e = edges;
        if (!in_reset && (e - rel) > DEPTH) begin
            if (ra) begin
                x.d = rd_model(aa, wa, bea, da);
                x.due = e;     sbq[0].push_back(x);
                x.due = e + 1; sbq[2].push_back(x);
            end
            if (rb) begin
                x.d = rd_model(ab, wb, beb, db);
                x.due = e;     sbq[1].push_back(x);
                x.due = e + 1; sbq[3].push_back(x);
            end
            if (wa && wb && aa == ab && (bea & beb) != 0) coll_exp[e] = 1'b1;
            // B first, then A on top: A wins any lane both enable.
            if (wb) wr_model(ab, beb, db);
            if (wa) wr_model(aa, bea, da);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic release_reset();
        rst_n    = 1'b1;
        rel      = edges;
        in_reset = 1'b0;
        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    endtask

    task automatic assert_reset();
        rst_n    = 1'b0;
        in_reset = 1'b1;
    endtask

    // Random reads on both ports; only meaningful outside the clear window.
    task automatic random_reads(input int n);
        for (int i = 0; i < n; i++)
            cyc(0, 0, 0, 0, 1'($urandom_range(0, 1)),
                0, AW'($urandom_range(0, DEPTH-1)), 0, 0, 1'($urandom_range(0, 1)));
    endtask

    // Monitor
    always @(negedge clk) begin
        logic [DW-1:0] qs [4];
        logic          vs [4];
        exp_t          x;
        qs[0] = q_a0; qs[1] = q_b0; qs[2] = q_a1; qs[3] = q_b1;
        vs[0] = qv_a0; vs[1] = qv_b0; vs[2] = qv_a1; vs[3] = qv_b1;
        if (in_reset) begin
            for (int k = 0; k < 4; k++) begin
                sbq[k].delete();
                last_exp[k] = '0;
            end
        end
        for (int k = 0; k < 4; k++) begin
            while (sbq[k].size() > 0 && sbq[k][0].due < edges) begin
                chk(1'b0, $sformatf("missing q_valid port%0d", k), '0, sbq[k][0].d);
                void'(sbq[k].pop_front());
            end
            if (vs[k]) begin
                if (sbq[k].size() == 0 || sbq[k][0].due != edges) begin
                    chk(1'b0, $sformatf("unexpected q_valid port%0d", k), qs[k], '0);
                end else begin
                    x = sbq[k].pop_front();
                    chk(qs[k] === x.d, $sformatf("read data port%0d", k), qs[k], x.d);
                    last_exp[k] = x.d;
                end
            end else begin
                chk(qs[k] === last_exp[k], $sformatf("q hold port%0d", k), qs[k], last_exp[k]);
            end
        end
        begin
            bit eb, ec;
            eb = in_reset || ((edges - rel) < DEPTH);
            ec = !in_reset && coll_exp.exists(edges);
            chk(busy0 === eb, "busy oreg0", DW'(busy0), DW'(eb));
            chk(busy1 === eb, "busy oreg1", DW'(busy1), DW'(eb));
            chk(coll0 === ec, "collision oreg0", DW'(coll0), DW'(ec));
            chk(coll1 === ec, "collision oreg1", DW'(coll1), DW'(ec));
        end
    end

    initial begin
        bit            wa, wb, ra, rb;
        bit [AW-1:0]   aa, ab;
        bit [NBL-1:0]  bea, beb;

        repeat (3) @(posedge clk);
        #1;
        release_reset();
        // Reads attempted during the clear window are ignored.
        random_reads(DEPTH + 2);
        // Every word reads back as zero, one read per cycle on each port.
        for (int i = 0; i < DEPTH; i++)
            cyc(0, 0, 0, 0, 1, 0, AW'(i), 0, 0, 1);
        for (int i = 0; i < DEPTH; i++)
            cyc(0, AW'(i), 0, 0, 1, 0, 0, 0, 0, 0);

        // Byte-lane merge, read back on B.
        cyc(1, 3, 4'hF, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0);
        cyc(1, 3, 4'h1, 32'h000000AA, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 3, 0, 0, 1);

        // Mixed-port read-during-write returns old, then new on A.
        cyc(0, 0, 0, 0, 0, 1, 5, 4'hF, 32'h22222222, 0);
        cyc(1, 5, 4'hF, 32'h11111111, 0, 0, 5, 0, 0, 1);
        cyc(0, 5, 0, 0, 1, 0, 0, 0, 0, 0);

        // Same-port read-during-write with partial lanes.
        cyc(1, 5, 4'h6, 32'h55667788, 1, 0, 0, 0, 0, 0);

        // Overlapping collision, then disjoint merge.
        cyc(1, 7, 4'h3, 32'hAAAAAAAA, 0, 1, 7, 4'hE, 32'hBBBBBBBB, 0);
        cyc(0, 7, 0, 0, 1, 0, 7, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 1, 7, 4'hF, 32'h0, 0);
        cyc(1, 7, 4'h3, 32'hAAAAAAAA, 0, 1, 7, 4'hC, 32'hBBBBBBBB, 0);
        cyc(0, 7, 0, 0, 1, 0, 7, 0, 0, 1);
        idle(3);

        // Randomized traffic on a small address space.
        for (int n = 0; n < 800; n++) begin
            wa  = 1'($urandom_range(0, 1));
            wb  = 1'($urandom_range(0, 1));
            ra  = 1'($urandom_range(0, 1));
            rb  = 1'($urandom_range(0, 1));
            aa  = AW'($urandom_range(0, DEPTH-1));
            ab  = ($urandom_range(0, 2) == 0) ? aa : AW'($urandom_range(0, DEPTH-1));
            bea = NBL'($urandom);
            beb = NBL'($urandom);
            // B reading its own word while A overwrites shared lanes is left out.
            if (rb && wb && wa && aa == ab && (bea & beb) != 0) rb = 1'b0;
            cyc(wa, aa, bea, DW'($urandom), ra, wb, ab, beb, DW'($urandom), rb);
        end
        idle(3);

        // Fill with non-zero data, then abort a clear at count 9.
        for (int i = 0; i < DEPTH; i++)
            cyc(1, AW'(i), 4'hF, DW'($urandom) | 32'h1, 0, 0, 0, 0, 0, 0);
        idle(3);
        assert_reset();
        idle(2);
        release_reset();
        random_reads(9);
        assert_reset();
        random_reads(3);
        release_reset();
        random_reads(DEPTH + 2);
        for (int i = 0; i < DEPTH; i++)
            cyc(0, AW'(i), 0, 0, 1, 0, AW'(DEPTH-1-i), 0, 0, 1);
        idle(4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/tdp_ram_ctrl.md
Name: tdp_ram_ctrl

Overview:
Parametrised true-dual-port synchronous RAM for CPU data/instruction memory, generalising the fixed 32-bit, 2^16-word dual-port memory. Adds configurable data width, per-byte write enables, an optional output register, read-valid strobes and a deterministic write-collision policy. Adds a post-reset hardware clear engine that zeroes the array. Ports A and B are symmetric, so one port can serve instruction fetch and the other load/store.

Parameters:
WIDTHAD, 16, address width; depth = 1<<WIDTHAD words
DATA_WIDTH, 32, word width in bits; must be a multiple of 8
NB, DATA_WIDTH/8, byte lanes (derived, not overridable)
OUT_REG, 0, 0 = read latency 1; 1 = extra output register, read latency 2
CLEAR_ON_RESET, 1, 1 = zero every word after reset release; 0 = contents untouched by reset

Ports:
clk  in  1  single clock, all logic rising-edge
rst_n  in  1  asynchronous active-low reset
busy  out  1  high while clear engine runs; port requests ignored
address_a  in  WIDTHAD  port A word address
wren_a  in  1  port A write strobe
byteena_a  in  NB  port A byte-lane write enables
data_a  in  DATA_WIDTH  port A write data
rden_a  in  1  port A read strobe
q_a  out  DATA_WIDTH  port A read data
q_valid_a  out  1  q_a carries fresh read data this cycle
address_b, wren_b, byteena_b, data_b, rden_b, q_b, q_valid_b: same as port A, for port B
collision  out  1  one-cycle pulse: both ports wrote the same address with overlapping byte enables

Behaviour:
- Reset (rst_n low, async): q_a=q_b=0, q_valid_a=q_valid_b=0, collision=0, clear counter=0, busy=CLEAR_ON_RESET. Array contents are not reset asynchronously.
- FSM states: IDLE, CLEAR. Reset enters CLEAR if CLEAR_ON_RESET, else IDLE.
- CLEAR: each cycle writes 0 to word clr_cnt, then clr_cnt++. After writing word depth-1, go to IDLE; busy drops on the following edge. Total busy = depth cycles after reset release.
- While busy: all wren/rden ignored; q_valid_* stay 0; q_* hold 0.
- Reset asserted mid-clear aborts the clear. On release, clearing restarts at word 0.
- Write (IDLE): at the rising edge with wren_x=1, lanes with byteena_x[i]=1 take data_x[8i+7:8i]. Other lanes keep their value. wren with byteena=0 changes nothing.
- Read: rden_x=1 at edge N. With OUT_REG=0, q_x is valid after edge N+1 and q_valid_x=1 for that one cycle. With OUT_REG=1, this happens after edge N+2.
- Reads are fully pipelined: a rden every cycle gives a q_valid every cycle.
- q_x holds its last value when no new read completes.
- Same-port read-during-write (rden_x and wren_x, same address): return new data in enabled lanes and old data in disabled lanes.
- Mixed-port read-during-write (port x reads address that port y writes in the same cycle): return OLD data.
- Write collision (both wren, equal address): per lane, port A wins where byteena_a[i]=1; otherwise port B's lane is written if byteena_b[i]=1.
- collision pulses 1 cycle after the edge only if (byteena_a & byteena_b) != 0. Disjoint lanes merge silently.
- Address is the full WIDTHAD bits; there is no wrap or out-of-range case.
- Array must infer block RAM for both widths: no async reads, no reset on the array.

Test Plan:
- Reset release with WIDTHAD=4, CLEAR_ON_RESET=1 -> busy high exactly 16 cycles; a read of every address afterwards returns 0 with q_valid one cycle after each rden.
- Port A writes 0xDEADBEEF to addr 3 (byteena=4'hF), then 0x000000AA with byteena=4'h1; port B reads addr 3 -> q_b=0xDEADBEAA; with OUT_REG=1, q_valid_b asserts 2 cycles after rden_b.
- Same cycle: A writes 0x11111111 to addr 5 (old 0x22222222) while B reads addr 5 -> q_b=0x22222222. Next cycle A reads addr 5 -> q_a=0x11111111.
- Both ports write addr 7: A 0xAAAAAAAA with byteena=4'h3, B 0xBBBBBBBB with byteena=4'hE -> word=0xBBBBAAAA; collision pulses once.
- Same test with B byteena=4'hC -> word=0xBBBBAAAA, collision stays 0.
- Assert rst_n low at clear count 9, release, issue reads during busy -> no q_valid; clearing restarts at 0 and busy lasts the full 16 cycles.
